// File: rtl/ahb3lite_sram_slave.sv
// rtl/ahb3lite_sram_slave.sv - AHB-Lite responder for a word-addressed SRAM
// Optional wait states per transfer when WAIT_STATE_EN is defined.
module ahb3lite_sram_slave #(
    parameter int          ADDR_WIDTH  = 6,
    parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef WAIT_STATE_EN
    localparam int WAITS = WAIT_CYCLES;
`else
    localparam int WAITS = WAIT_CYCLES * 0;
`endif

    typedef enum logic [2:0] {IDLE_S, DATA_S, WAIT_S, ERR1_S, ERR2_S} state_t;

    state_t                  state;
    logic                    pend;
    logic                    wr;
    logic                    bad;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [7:0]              wcnt;
    logic [31:0]             mem [DEPTH];

    logic [31:0]             offset;
    logic [ADDR_WIDTH-1:0]   new_idx;
    logic                    legal;
    logic                    accept;
    logic                    commit;
    logic [31:0]             rd_word;
    logic                    unused;

    // Unsigned offset: addresses below MEM_BASE wrap to huge values and fail the range test
    assign offset  = HADDR - MEM_BASE;
    assign new_idx = offset[ADDR_WIDTH-1:0];
    assign legal   = ((offset >> ADDR_WIDTH) == 32'd0) && (HSIZE == 3'b010);
    assign accept  = HSEL && HREADY && HREADYOUT && HTRANS[1];
    assign commit  = (state == DATA_S) && wr && pend;
    assign rd_word = (commit && (idx == new_idx)) ? HWDATA : mem[new_idx];
    assign unused  = ^{HBURST, HTRANS[0]};

    always_ff @(posedge HCLK) begin
        if (!HRESET && commit) begin
            mem[idx] <= HWDATA;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= IDLE_S;
            pend      <= 1'b0;
            wr        <= 1'b0;
            bad       <= 1'b0;
            idx       <= '0;
            wcnt      <= 8'd0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= 32'h0;
        end else begin
            case (state)
                WAIT_S: begin
                    if (wcnt == 8'd0) begin
                        if (bad) begin
                            state <= ERR1_S;
                            HRESP <= 1'b1;
                        end else begin
                            state     <= DATA_S;
                            HREADYOUT <= 1'b1;
                        end
                    end else begin
                        wcnt <= wcnt - 8'd1;
                    end
                end
                ERR1_S: begin
                    state     <= ERR2_S;
                    HREADYOUT <= 1'b1;
                end
                default: begin
                    // IDLE_S, DATA_S and ERR2_S all present HREADYOUT=1, so a new address phase may chain
                    if (accept) begin
                        pend   <= 1'b1;
                        idx    <= new_idx;
                        wr     <= HWRITE;
                        bad    <= !legal;
                        HRDATA <= (legal && !HWRITE) ? rd_word : 32'h0;
                        if (WAITS > 0) begin
                            state     <= WAIT_S;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b0;
                            wcnt      <= 8'(WAITS - 1);
                        end else if (legal) begin
                            state     <= DATA_S;
                            HREADYOUT <= 1'b1;
                            HRESP     <= 1'b0;
                        end else begin
                            state     <= ERR1_S;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end
                    end else begin
                        state     <= IDLE_S;
                        pend      <= 1'b0;
                        wr        <= 1'b0;
                        bad       <= 1'b0;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                        HRDATA    <= 32'h0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// tb/tb_ahb3lite_sram_slave.sv - self-checking bench for ahb3lite_sram_slave
module tb_ahb3lite_sram_slave;

    localparam int          ADDR_WIDTH  = 6;
    localparam logic [31:0] MEM_BASE    = 32'h0000_0000;
    localparam int          WAIT_CYCLES = 2;
    localparam int          DEPTH       = 1 << ADDR_WIDTH;
`ifdef WAIT_STATE_EN
    localparam int          WAITS       = WAIT_CYCLES;
`else
    localparam int          WAITS       = 0;
`endif

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam int OP_BUS = 0, OP_RST = 1;

    logic        HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [1:0]  HTRANS;

    ahb3lite_sram_slave #(
        .ADDR_WIDTH(ADDR_WIDTH), .MEM_BASE(MEM_BASE), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    // Single slave on the bus: the interconnect's global ready is this slave's ready
    assign HREADY = HREADYOUT;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        int          op;
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic        lit_en;
        logic [31:0] lit;
    } step_t;

    typedef struct {
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t        expq[$];
    exp_t        cur;
    step_t       steps[$];
    logic [31:0] mem_m [DEPTH];
    logic        pend_v;
    int          pend_i;
    logic [31:0] pend_d;
    logic        chk_en;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic step_t mk(input int op, input logic sel, input logic [1:0] tr, input logic wr,
                                 input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                                 input logic le, input logic [31:0] lit);
        step_t s;
        s.op = op; s.sel = sel; s.trans = tr; s.write = wr; s.addr = a;
        s.size = sz; s.data = d; s.lit_en = le; s.lit = lit;
        return s;
    endfunction

    function automatic step_t wr_step(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] d);
        return mk(OP_BUS, 1'b1, tr, 1'b1, a, 3'b010, d, 1'b0, 32'h0);
    endfunction

    function automatic step_t rd_step(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] lit);
        return mk(OP_BUS, 1'b1, tr, 1'b0, a, 3'b010, 32'h0, 1'b1, lit);
    endfunction

    function automatic step_t rst_step();
        return mk(OP_RST, 1'b0, T_IDLE, 1'b0, 32'h0, 3'b000, 32'h0, 1'b0, 32'h0);
    endfunction

    task automatic push_exp(input logic rdy, input logic resp, input logic [31:0] rdata);
        exp_t e;
        e.rdy = rdy; e.resp = resp; e.rdata = rdata;
        expq.push_back(e);
    endtask

    // Transaction-level model: what the bus must see after this address phase is taken
    task automatic model_step(input step_t s, output int n);
        logic [31:0] off;
        logic [31:0] rd;
        n  = 0;
        rd = 32'h0;
        if (!s.sel || (s.trans != T_NSEQ && s.trans != T_SEQ)) begin
            push_exp(1'b1, 1'b0, 32'h0);
            n = 1;
        end else begin
            off = s.addr - MEM_BASE;
            for (int k = 0; k < WAITS; k++) begin
                push_exp(1'b0, 1'b0, 32'h0);
                n++;
            end
            if (off < 32'(DEPTH) && s.size == 3'b010) begin
                if (!s.write) rd = mem_m[int'(off)];
                push_exp(1'b1, 1'b0, rd);
                n++;
                if (s.write) begin
                    pend_v = 1'b1;
                    pend_i = int'(off);
                    pend_d = s.data;
                end
            end else begin
                push_exp(1'b0, 1'b1, 32'h0);
                push_exp(1'b1, 1'b1, 32'h0);
                n += 2;
            end
        end
        if (s.lit_en) check32("model_read_value", rd, s.lit);
    endtask

    always @(negedge HCLK) begin
        if (chk_en) begin
            if (expq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL model_underrun: no expectation at %0t", $time);
            end else begin
                cur = expq.pop_front();
                check1("hreadyout", HREADYOUT, cur.rdy);
                check1("hresp", HRESP, cur.resp);
                if (cur.rdy) check32("hrdata", HRDATA, cur.rdata);
            end
        end
    end

    initial begin
        step_t       s;
        int          n;
        logic [31:0] prev_data;

        chk_en = 1'b0; pend_v = 1'b0; pend_i = 0; pend_d = 32'h0; prev_data = 32'h0;
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = T_IDLE; HWRITE = 1'b0; HADDR = 32'h0;
        HWDATA = 32'h0; HSIZE = 3'b010; HBURST = 3'b001;

        repeat (2) @(negedge HCLK);
        #1;
        check1("reset_hreadyout", HREADYOUT, 1'b1);
        check1("reset_hresp", HRESP, 1'b0);
        check32("reset_hrdata", HRDATA, 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        #1;
        push_exp(1'b1, 1'b0, 32'h0);
        chk_en = 1'b1;

        steps.push_back(wr_step(T_NSEQ, 32'd3, 32'hA5A5_0001));
        steps.push_back(rd_step(T_NSEQ, 32'd3, 32'hA5A5_0001));
        steps.push_back(wr_step(T_NSEQ, 32'd10, 32'd1));
        steps.push_back(wr_step(T_SEQ, 32'd9, 32'd2));
        steps.push_back(mk(OP_BUS, 1'b1, T_BUSY, 1'b1, 32'd8, 3'b010, 32'hBAD0_0BAD, 1'b0, 32'h0));
        steps.push_back(wr_step(T_SEQ, 32'd8, 32'd3));
        steps.push_back(wr_step(T_SEQ, 32'd7, 32'd4));
        steps.push_back(rd_step(T_NSEQ, 32'd10, 32'd1));
        steps.push_back(rd_step(T_SEQ, 32'd9, 32'd2));
        steps.push_back(rd_step(T_SEQ, 32'd8, 32'd3));
        steps.push_back(rd_step(T_SEQ, 32'd7, 32'd4));
        steps.push_back(wr_step(T_NSEQ, 32'd20, 32'h0000_1234));
        steps.push_back(rd_step(T_NSEQ, 32'd20, 32'h0000_1234));
        steps.push_back(wr_step(T_NSEQ, 32'd0, 32'h00C0_FFEE));
        steps.push_back(wr_step(T_NSEQ, 32'd2, 32'h0000_0022));
        steps.push_back(wr_step(T_NSEQ, 32'd64, 32'hBAD0_0BAD));
        steps.push_back(rd_step(T_NSEQ, 32'd0, 32'h00C0_FFEE));
        steps.push_back(mk(OP_BUS, 1'b1, T_NSEQ, 1'b1, 32'd2, 3'b000, 32'hBAD0_0BAD, 1'b0, 32'h0));
        steps.push_back(rd_step(T_NSEQ, 32'd2, 32'h0000_0022));
        steps.push_back(wr_step(T_NSEQ, 32'd1, 32'h0000_000A));
        steps.push_back(wr_step(T_SEQ, 32'd0, 32'h0000_000B));
        steps.push_back(wr_step(T_SEQ, 32'hFFFF_FFFF, 32'h0000_000C));
        steps.push_back(rd_step(T_NSEQ, 32'd1, 32'h0000_000A));
        steps.push_back(rd_step(T_SEQ, 32'd0, 32'h0000_000B));
        steps.push_back(mk(OP_BUS, 1'b1, T_IDLE, 1'b1, 32'd3, 3'b010, 32'hBAD0_0BAD, 1'b0, 32'h0));
        steps.push_back(mk(OP_BUS, 1'b0, T_NSEQ, 1'b1, 32'd3, 3'b010, 32'hBAD0_0BAD, 1'b0, 32'h0));
        steps.push_back(rd_step(T_NSEQ, 32'd3, 32'hA5A5_0001));
        steps.push_back(wr_step(T_NSEQ, 32'd5, 32'h0000_0055));
        steps.push_back(rd_step(T_NSEQ, 32'd3, 32'hA5A5_0001));
        steps.push_back(rst_step());
        steps.push_back(wr_step(T_NSEQ, 32'd5, 32'hDEAD_BEEF));
        steps.push_back(rst_step());
        steps.push_back(rd_step(T_NSEQ, 32'd5, 32'h0000_0055));
        steps.push_back(mk(OP_BUS, 1'b1, T_IDLE, 1'b0, 32'd0, 3'b010, 32'h0, 1'b0, 32'h0));

        foreach (steps[i]) begin
            s = steps[i];
            @(negedge HCLK);
            HWDATA = prev_data;
            if (s.op == OP_RST) begin
                pend_v = 1'b0;
                #1;
                chk_en = 1'b0;
                HRESET = 1'b1;
                #1;
                check1("midreset_hreadyout", HREADYOUT, 1'b1);
                check1("midreset_hresp", HRESP, 1'b0);
                check32("midreset_hrdata", HRDATA, 32'h0);
                HSEL = 1'b0;
                HTRANS = T_IDLE;
                @(negedge HCLK);
                HRESET = 1'b0;
                #1;
                expq.delete();
                push_exp(1'b1, 1'b0, 32'h0);
                chk_en = 1'b1;
                prev_data = 32'h0;
            end else begin
                if (pend_v) mem_m[pend_i] = pend_d;
                pend_v = 1'b0;
                HSEL = s.sel; HTRANS = s.trans; HWRITE = s.write;
                HADDR = s.addr; HSIZE = s.size;
                model_step(s, n);
                prev_data = s.data;
                for (int j = 1; j < n; j++) begin
                    @(negedge HCLK);
                    HWDATA = s.data;
                end
            end
        end

        @(posedge HCLK);
        @(posedge HCLK);
        chk_en = 1'b0;
        check32("expectations_drained", 32'(expq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
